reg_file_wb_sink: RTL

//   Integer register file; receiving end of the WB stage write interface (RegWrite/RegisterRd/WriteData).

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_read_port.sv | 25 ++
 rtl/reg_file_wb_sink.sv | 104 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the integer register file and its WB write interface.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int REG_ZERO = 0;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_word_t;

  // One WB-stage write as seen by the register file.
  typedef struct packed {
    logic      we;
    reg_idx_t  rd;
    reg_word_t data;
  } wb_wr_t;

  // Register 0 is architecturally zero; every consumer checks against it the same way.
  function automatic logic is_zero_idx(input reg_idx_t idx);
    return idx == reg_idx_t'(REG_ZERO);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: returns zero for x0, optionally forwards the
// write being committed this cycle, otherwise returns the stored value.
module rf_read_port
  import rf_pkg::*;
(
  input  reg_idx_t  rd_idx,
  input  reg_word_t regs [NUM_REGS],
  input  wb_wr_t    wb,
  input  logic      byp_en,
  output reg_word_t rd_data
);

  // Zero / bypass / array select for this port.
  always_comb begin
    rd_data = '0;
    if (!is_zero_idx(rd_idx)) begin
      if (byp_en && wb.we && !is_zero_idx(wb.rd) && (wb.rd == rd_idx)) begin
        rd_data = wb.data;
      end else begin
        rd_data = regs[rd_idx];
      end
    end
  end

endmodule

// File: rtl/reg_file_wb_sink.sv
// Integer register file fed by the WB stage: one write per clock, two ID-stage
// read ports with optional same-cycle forwarding, one unforwarded debug port,
// and a saturating count of committed writes.
// DATA_W / ADDR_W / NUM_REGS must stay equal to the rf_pkg values because the
// storage and the read ports are built from the package types.
module reg_file_wb_sink #(
  parameter int DATA_W    = rf_pkg::DATA_W,
  parameter int ADDR_W    = rf_pkg::ADDR_W,
  parameter int NUM_REGS  = rf_pkg::NUM_REGS,
  parameter int BYPASS_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RegisterRd,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WriteCount
);

  import rf_pkg::*;

  localparam logic BYP_ON = (BYPASS_EN != 0);

  wb_wr_t    wb;
  logic      commit;
  reg_word_t regs_q [NUM_REGS];
  reg_word_t regs_d [NUM_REGS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Bundle the WB write; it is suppressed while reset is held so nothing
  // (including the bypass path) can leak data out during reset.
  always_comb begin
    wb.we   = RegWrite & rst_n;
    wb.rd   = RegisterRd;
    wb.data = WriteData;
    commit  = wb.we & ~is_zero_idx(wb.rd);
  end

  // Write decode: only the addressed register changes; x0 is forced to zero.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[wb.rd] = wb.data;
    end
    regs_d[REG_ZERO] = '0;
  end

  // Committed-write counter, saturating at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (commit && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Storage and counter; reset clears immediately, dropping any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign WriteCount = cnt_q;

  rf_read_port u_port1 (
    .rd_idx  (ReadRegister1),
    .regs    (regs_q),
    .wb      (wb),
    .byp_en  (BYP_ON),
    .rd_data (ReadData1)
  );

  rf_read_port u_port2 (
    .rd_idx  (ReadRegister2),
    .regs    (regs_q),
    .wb      (wb),
    .byp_en  (BYP_ON),
    .rd_data (ReadData2)
  );

  // Debug port always shows committed state only.
  rf_read_port u_port_dbg (
    .rd_idx  (DbgAddr),
    .regs    (regs_q),
    .wb      (wb),
    .byp_en  (1'b0),
    .rd_data (DbgData)
  );

endmodule
